// File: rtl/imm_gen_pkg.sv
// Shared type codes and funct3 constants for the decode-stage immediate generator.
package imm_gen_pkg;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_U    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_S    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;
    localparam logic [2:0] IMM_ALU  = 3'b110;
    localparam logic [2:0] IMM_ZIMM = 3'b111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: raw instruction + type code -> XLEN-wide immediate.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [2:0]      type_i,
    output logic [XLEN-1:0] imm_o
);

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst_i[6:0];

    logic is_shift;
    assign is_shift = (inst_i[14:12] == F3_SLL) || (inst_i[14:12] == F3_SRX);

    // Sign-extending types preload the whole word with inst[31], then fill the low bits.
    always_comb begin
        imm_o = '0;
        unique case (type_i)
            IMM_I: begin
                imm_o        = {XLEN{inst_i[31]}};
                imm_o[11:0]  = inst_i[31:20];
            end
            IMM_U: begin
                imm_o        = {XLEN{inst_i[31]}};
                imm_o[31:0]  = {inst_i[31:12], 12'b0};
            end
            IMM_B: begin
                imm_o        = {XLEN{inst_i[31]}};
                imm_o[12:0]  = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            IMM_S: begin
                imm_o        = {XLEN{inst_i[31]}};
                imm_o[11:0]  = {inst_i[31:25], inst_i[11:7]};
            end
            IMM_J: begin
                imm_o        = {XLEN{inst_i[31]}};
                imm_o[20:0]  = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            IMM_ALU: begin
                if (is_shift) begin
                    imm_o = '0;
                    if (XLEN == 64) imm_o[5:0] = inst_i[25:20];
                    else            imm_o[4:0] = inst_i[24:20];
                end else begin
                    imm_o       = {XLEN{inst_i[31]}};
                    imm_o[11:0] = inst_i[31:20];
                end
            end
            IMM_ZIMM: imm_o[4:0] = inst_i[19:15];
            default:  imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer; in_ready depends only on
// stored state, so downstream back-pressure never reaches fetch combinationally.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  ext_imm;
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, pop, main_free;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst_i (in_inst),
        .type_i (in_type),
        .imm_o  (ext_imm)
    );

    assign accept    = in_valid && in_ready_q;
    assign pop       = main_valid_q && out_ready;
    assign main_free = !main_valid_q || pop;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // Older skid beat moves up first to keep acceptance order.
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_imm_d = ext_imm;
                    skid_tag_d = in_tag;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_imm_d = ext_imm;
                    main_tag_d = in_tag;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_imm;
            skid_tag_d   = in_tag;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_imm   = main_imm_q;
    assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: XLEN=32 and XLEN=64 instances share stimulus; vector table plus handshake corners.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_type;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] out_imm32, out_tag32, out_tag64;
    logic [63:0] out_imm64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
        .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
        .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [31:0] e32;
        logic [63:0] e64;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks output-side state of both instances in one call.
    task automatic chk_out(input string name, input logic vld, input logic rdy, input logic [31:0] tag);
        chk({name, " out_valid32"}, 64'(out_valid32), 64'(vld));
        chk({name, " out_valid64"}, 64'(out_valid64), 64'(vld));
        chk({name, " in_ready32"},  64'(in_ready32),  64'(rdy));
        chk({name, " in_ready64"},  64'(in_ready64),  64'(rdy));
        if (vld) begin
            chk({name, " out_tag32"}, 64'(out_tag32), 64'(tag));
            chk({name, " out_tag64"}, 64'(out_tag64), 64'(tag));
        end
    endtask

    initial begin
        v[0]  = '{32'hFFF00093, 3'b001, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}; // addi -1
        v[1]  = '{32'h7FF00093, 3'b001, 32'h000007FF, 64'h00000000000007FF};
        v[2]  = '{32'h40515093, 3'b110, 32'h00000005, 64'h0000000000000005}; // srai 5
        v[3]  = '{32'h42115093, 3'b110, 32'h00000001, 64'h0000000000000021}; // srai 33
        v[4]  = '{32'hFFF00093, 3'b110, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}; // funct3 000
        v[5]  = '{32'hFFDFF06F, 3'b101, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC}; // jal -4
        v[6]  = '{32'h0080006F, 3'b101, 32'h00000008, 64'h0000000000000008}; // jal +8
        v[7]  = '{32'hFE000EE3, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC}; // beq -4
        v[8]  = '{32'h00000463, 3'b011, 32'h00000008, 64'h0000000000000008}; // beq +8
        v[9]  = '{32'h800000B7, 3'b010, 32'h80000000, 64'hFFFFFFFF80000000}; // lui
        v[10] = '{32'h12345037, 3'b010, 32'h12345000, 64'h0000000012345000};
        v[11] = '{32'hFE112C23, 3'b100, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8}; // sw -8
        v[12] = '{32'hFFFFFFFF, 3'b111, 32'h0000001F, 64'h000000000000001F}; // zimm
        v[13] = '{32'hFFFFFFFF, 3'b000, 32'h00000000, 64'h0000000000000000}; // none

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_type = '0;
        in_tag = '0; out_ready = 1'b0;
        #1;
        chk("reset out_imm32", 64'(out_imm32), 64'h0);
        chk("reset out_imm64", out_imm64, 64'h0);
        chk("reset out_tag", 64'(out_tag32), 64'h0);
        chk_out("reset", 1'b0, 1'b1, 32'h0);
        #11 rst = 1'b0;
        step();

        // Streaming table: one beat per cycle, each checked the cycle after acceptance.
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; in_inst = v[i].inst; in_type = v[i].typ;
            in_tag = 32'(100 + i); out_ready = 1'b1;
            step();
            chk_out($sformatf("vec%0d", i), 1'b1, 1'b1, 32'(100 + i));
            chk($sformatf("vec%0d imm32", i), 64'(out_imm32), 64'(v[i].e32));
            chk($sformatf("vec%0d imm64", i), out_imm64, v[i].e64);
        end
        in_valid = 1'b0;
        step();
        chk_out("drain", 1'b0, 1'b1, 32'h0);

        // Back-pressure: tags 1,2,3 with out_ready low, then release.
        out_ready = 1'b0; in_inst = 32'hFFF00093; in_type = 3'b001;
        in_valid = 1'b1; in_tag = 32'd1; step();
        chk_out("bp t1", 1'b1, 1'b1, 32'd1);
        in_tag = 32'd2; in_inst = 32'h7FF00093; step();
        chk_out("bp t2", 1'b1, 1'b0, 32'd1);
        chk("bp hold imm", 64'(out_imm32), 64'hFFFFFFFF);
        in_tag = 32'd3; in_inst = 32'h12345037; in_type = 3'b010; step();
        chk_out("bp t3 held", 1'b1, 1'b0, 32'd1);
        chk("bp hold imm2", 64'(out_imm32), 64'hFFFFFFFF);
        out_ready = 1'b1; step();
        chk_out("bp pop1", 1'b1, 1'b1, 32'd2);
        chk("bp imm2", 64'(out_imm32), 64'h7FF);
        step();
        chk_out("bp pop2", 1'b1, 1'b1, 32'd3);
        chk("bp imm3", 64'(out_imm32), 64'h12345000);
        in_valid = 1'b0; step();
        chk_out("bp empty", 1'b0, 1'b1, 32'h0);

        // Flush with both entries full and a beat presented.
        out_ready = 1'b0; in_inst = 32'hFFF00093; in_type = 3'b001;
        in_valid = 1'b1; in_tag = 32'h10; step();
        in_tag = 32'h11; step();
        chk_out("fl full", 1'b1, 1'b0, 32'h10);
        flush = 1'b1; in_tag = 32'h12; step();
        chk_out("fl next", 1'b0, 1'b1, 32'h0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        chk_out("fl after", 1'b0, 1'b1, 32'h0);

        // Flush while main is full and in_ready is high: presented beat must be dropped.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'h20; step();
        flush = 1'b1; in_tag = 32'h21; step();
        chk_out("fl drop", 1'b0, 1'b1, 32'h0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        chk_out("fl drop after", 1'b0, 1'b1, 32'h0);

        // Async reset mid-cycle with both entries full.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'h30; step();
        in_tag = 32'h31; step();
        chk_out("rst pre", 1'b1, 1'b0, 32'h30);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_out("rst async", 1'b0, 1'b1, 32'h0);
        chk("rst async imm32", 64'(out_imm32), 64'h0);
        chk("rst async tag", 64'(out_tag32), 64'h0);
        @(negedge clk); rst = 1'b0;
        step();
        in_valid = 1'b1; in_tag = 32'h40; in_inst = 32'hFFDFF06F; in_type = 3'b101;
        out_ready = 1'b1; step();
        chk_out("rst first beat", 1'b1, 1'b1, 32'h40);
        chk("rst first imm64", out_imm64, 64'hFFFFFFFFFFFFFFFC);
        in_valid = 1'b0; step();
        chk_out("rst drained", 1'b0, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Extracts and extends I/U/B/S/J, shift and CSR-zimm immediates for XLEN = 32 or 64.
- Carries a sideband tag (PC, rd, etc.) alongside each immediate.
- Valid/ready handshake on both sides, with a 2-entry skid buffer, so decode back-pressure never forms a combinational path to fetch.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each instruction.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_inst  in  32  raw instruction word
- in_type  in  3  immediate type code
- in_tag  in  TAG_W  sideband carried with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_imm  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the beat on out_imm

Behaviour:
- Type codes. All sign extension is from inst[31] to XLEN.
  - 000: none, imm = 0.
  - 001: I, sext(inst[31:20]).
  - 010: U, sext({inst[31:12], 12'b0}); upper bits sign-extend when XLEN=64.
  - 011: B, sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 100: S, sext({inst[31:25], inst[11:7]}).
  - 101: J, sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 110: ALU-I shift-aware. If funct3 (inst[14:12]) is 001 or 101, imm = zero-extended shamt: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64. Otherwise as 001.
  - 111: CSR zimm, zero-extended inst[19:15].
- Storage: main register (drives out_*) and one skid register, each with a valid bit.
- Reset (async, asserted): main_valid=0, skid_valid=0, out_imm=0, out_tag=0, out_valid=0, in_ready=1. Reset mid-stream discards all held beats.
- in_ready is registered and equals !skid_valid. There is no combinational path from out_ready to in_ready.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1 when main is free.
- Per-cycle update, with accept = in_valid && in_ready and pop = out_valid && out_ready:
  - main empty or pop, and skid_valid: main <= skid, skid cleared. A concurrent accept loads skid.
  - main empty or pop, and !skid_valid: accept loads main directly.
  - main full and !pop: accept loads skid.
- Beats leave strictly in acceptance order; no beat is dropped or duplicated.
- Output is stable: out_imm and out_tag hold while out_valid && !out_ready.
- Data registers (out_imm/out_tag, skid data) load only on a valid write; they are not cleared on pop.
- flush (synchronous, highest priority):
  - main_valid and skid_valid clear next cycle.
  - A beat presented in the flush cycle is dropped.
  - in_ready is 1 in the following cycle.
  - Data registers keep their stale values.
- Simultaneous pop and accept while full: throughput is one beat per cycle with no bubble.
- in_type 110 with funct3 001/101 and XLEN=32 ignores inst[25]; decoding illegal shamt is not this block's job.
- Elaboration fails if XLEN is not 32 or 64.

Decomposition:
- Package imm_gen_pkg holds:
  - localparams for the 3-bit type codes (IMM_NONE, IMM_I, IMM_U, IMM_B, IMM_S, IMM_J, IMM_ALU, IMM_ZIMM);
  - funct3 constants F3_SLL=3'b001 and F3_SRX=3'b101.
- One combinational sub-module, imm_extract (parameter XLEN), maps inst+type to imm. imm_gen_pipe instantiates it once on the input side and registers its result.
- The skid control stays in imm_gen_pipe.

Test Plan:
- XLEN=32, I-type: in_inst=0xFFF00093 (addi x1,x0,-1), type=001, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag matches.
- XLEN=32, shift path: inst=0x40515093 (srai x1,x2,5), type=110 -> out_imm=0x00000005. XLEN=64, inst=0x42115093 (srai, shamt 33) -> out_imm=0x21.
- J, B and U: inst=0xFFDFF06F (jal x0,-4), type=101 -> 0xFFFFFFFC. inst=0xFE000EE3 (beq x0,x0,-4), type=011 -> 0xFFFFFFFC. XLEN=64, inst=0x800000B7 (lui), type=010 -> 0xFFFFFFFF80000000.
- Back-pressure: hold out_ready=0 and push tags 1,2,3 on consecutive cycles:
  - tag1 in main, tag2 in skid, in_ready=0, tag3 held upstream.
  - Then out_ready=1 -> outputs tags 1,2,3 on consecutive cycles, no bubble.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- Async reset asserted mid-stream between clock edges -> out_valid=0 and out_imm=0 immediately; after release, the first accepted beat emerges normally.
